// File: rtl/i2c_mem_arbiter.sv
// Shares one synchronous single-port RAM between the I2C subordinate and a local
// host. Accesses run IDLE -> ACCESS -> RESP, with a starvation guard for the host.
module i2c_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter bit I2C_PRIORITY = 1'b1,
  parameter int MAX_WAIT     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_ack,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_i2c
);

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACCESS = 3'b010,
    RESP   = 3'b100
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t            state, state_nxt;
  logic              any_req, pick_i2c, rd_done;
  logic              last_grant_i2c;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] i2c_rdata_q, host_rdata_q;
  logic [3:0]        wait_cnt;

  assign any_req = i2c_req | host_req;

  // A starved host beats everything; otherwise fixed priority or alternate.
  always_comb begin
    pick_i2c = i2c_req;
    if (i2c_req && host_req) begin
      if (wait_cnt == WAIT_MAX) pick_i2c = 1'b0;
      else if (I2C_PRIORITY)    pick_i2c = 1'b1;
      else                      pick_i2c = ~last_grant_i2c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_en    = (state == ACCESS);
    mem_we    = (state == ACCESS) && cmd_we;
    mem_addr  = cmd_addr;
    mem_wdata = cmd_wdata;
    i2c_ack   = (state == RESP) && grant_i2c;
    host_ack  = (state == RESP) && !grant_i2c;
    rd_done   = (state == RESP) && !cmd_we;
    // The RAM output register loads on the edge entering RESP; pass it through
    // while ack is high, then hold the captured copy until the next read.
    i2c_rdata  = (rd_done && grant_i2c)  ? mem_rdata : i2c_rdata_q;
    host_rdata = (rd_done && !grant_i2c) ? mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we         <= 1'b0;
      cmd_addr       <= '0;
      cmd_wdata      <= '0;
      grant_i2c      <= 1'b0;
      last_grant_i2c <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      if (state == IDLE) begin
        if (!host_req) wait_cnt <= '0;
        if (any_req) begin
          cmd_we    <= pick_i2c ? i2c_we    : host_we;
          cmd_addr  <= pick_i2c ? i2c_addr  : host_addr;
          cmd_wdata <= pick_i2c ? i2c_wdata : host_wdata;
          grant_i2c <= pick_i2c;
          if (!pick_i2c)                             wait_cnt <= '0;
          else if (host_req && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
        end
      end
      if (state == RESP) last_grant_i2c <= grant_i2c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else if (rd_done) begin
      if (grant_i2c) i2c_rdata_q  <= mem_rdata;
      else           host_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Bench for i2c_mem_arbiter: two instances (fixed priority, round-robin), each with
// its own RAM, checked every cycle against a transaction-schedule model.
module tb_i2c_mem_arbiter;

  localparam int MAXW = 4;
  localparam int I2C  = 0;
  localparam int HOST = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      i2c_req, i2c_we, i2c_ack, host_req, host_we, host_ack;
  logic [1:0]      mem_en, mem_we, busy, grant_i2c;
  logic [1:0][7:0] i2c_addr, i2c_wdata, i2c_rdata, host_addr, host_wdata, host_rdata;
  logic [1:0][7:0] mem_addr, mem_wdata;
  logic [1:0][7:0] mem_rdata = '0;
  logic [7:0]      ram [2][256] = '{default: 8'h00};

  // Instance 0: I2C fixed priority. Instance 1: round-robin.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    i2c_mem_arbiter #(
      .ADDR_W(8), .DATA_W(8), .I2C_PRIORITY(k == 0), .MAX_WAIT(MAXW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i2c_req(i2c_req[k]), .i2c_we(i2c_we[k]), .i2c_addr(i2c_addr[k]),
      .i2c_wdata(i2c_wdata[k]), .i2c_ack(i2c_ack[k]), .i2c_rdata(i2c_rdata[k]),
      .host_req(host_req[k]), .host_we(host_we[k]), .host_addr(host_addr[k]),
      .host_wdata(host_wdata[k]), .host_ack(host_ack[k]), .host_rdata(host_rdata[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]),
      .busy(busy[k]), .grant_i2c(grant_i2c[k])
    );
  end

  // Synchronous RAMs with one-cycle read latency.
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (mem_en[k]) begin
        if (mem_we[k]) ram[k][mem_addr[k]] <= mem_wdata[k];
        else           mem_rdata[k]        <= ram[k][mem_addr[k]];
      end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rate   = 0;
  bit drop_en = 1'b0;

  // Requesters
  bit         act [2][2];
  bit         drp [2][2];
  bit         hold [2][2];
  bit         op_we [2][2];
  logic [7:0] op_addr [2][2];
  logic [7:0] op_wdata [2][2];

  // Model: one in-flight transaction per instance, decided at cycle g.
  bit         tv [2];
  int         g [2];
  int         gs [2];
  bit         gwe [2];
  logic [7:0] gaddr [2];
  logic [7:0] gwd [2];
  int         wcnt [2];
  bit         last_i2c [2];
  bit         e_gnt [2];
  bit         e_en [2];
  bit         e_busy [2];
  bit         e_ack [2][2];
  logic [7:0] e_rd [2][2];
  logic [7:0] ref_mem [2][256] = '{default: 8'h00};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic set_op(input int k, input int s, input bit we, input logic [7:0] a,
                        input logic [7:0] d);
    act[k][s]      = 1'b1;
    drp[k][s]      = 1'b0;
    op_we[k][s]    = we;
    op_addr[k][s]  = a;
    op_wdata[k][s] = d;
  endtask

  task automatic rand_op(input int k, input int s);
    set_op(k, s, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      i2c_req[k]    = act[k][I2C] && !drp[k][I2C];
      i2c_we[k]     = op_we[k][I2C];
      i2c_addr[k]   = op_addr[k][I2C];
      i2c_wdata[k]  = op_wdata[k][I2C];
      host_req[k]   = act[k][HOST] && !drp[k][HOST];
      host_we[k]    = op_we[k][HOST];
      host_addr[k]  = op_addr[k][HOST];
      host_wdata[k] = op_wdata[k][HOST];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      tv[k] = 1'b0; wcnt[k] = 0; last_i2c[k] = 1'b0; e_gnt[k] = 1'b0;
      e_en[k] = 1'b0; e_busy[k] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        e_ack[k][s] = 1'b0; e_rd[k][s] = 8'h00;
        act[k][s] = 1'b0; drp[k][s] = 1'b0; hold[k][s] = 1'b0;
        op_we[k][s] = 1'b0; op_addr[k][s] = 8'h00; op_wdata[k][s] = 8'h00;
      end
    end
  endtask

  task automatic step();
    int w;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        if (e_ack[k][s]) begin
          act[k][s] = 1'b0;
          drp[k][s] = 1'b0;
          if (hold[k][s]) rand_op(k, s);
        end else if (!act[k][s] && rate > 0 && $urandom_range(99) < rate) begin
          rand_op(k, s);
        end
      end
      if (drop_en && tv[k] && cyc == g[k] + 1 && $urandom_range(3) == 0) drp[k][gs[k]] = 1'b1;
    end
    drive();
    for (int k = 0; k < 2; k++) begin
      e_en[k]   = tv[k] && cyc == g[k] + 1;
      e_busy[k] = tv[k] && (cyc == g[k] + 1 || cyc == g[k] + 2);
      for (int s = 0; s < 2; s++) e_ack[k][s] = tv[k] && cyc == g[k] + 2 && gs[k] == s;
      if (e_en[k]) e_gnt[k] = (gs[k] == I2C);
      if (tv[k] && cyc == g[k] + 2) begin
        if (gwe[k]) ref_mem[k][gaddr[k]] = gwd[k];
        else        e_rd[k][gs[k]] = ref_mem[k][gaddr[k]];
        last_i2c[k] = (gs[k] == I2C);
      end
      if (!tv[k] || cyc >= g[k] + 3) begin
        if (!host_req[k]) wcnt[k] = 0;
        if (i2c_req[k] || host_req[k]) begin
          if (!host_req[k])       w = I2C;
          else if (!i2c_req[k])   w = HOST;
          else if (wcnt[k] == MAXW) w = HOST;
          else if (k == 0)        w = I2C;
          else                    w = last_i2c[k] ? HOST : I2C;
          if (w == HOST)                          wcnt[k] = 0;
          else if (host_req[k] && wcnt[k] < MAXW) wcnt[k]++;
          tv[k] = 1'b1; g[k] = cyc; gs[k] = w;
          gwe[k] = op_we[k][w]; gaddr[k] = op_addr[k][w]; gwd[k] = op_wdata[k][w];
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      string p;
      p = $sformatf("cyc%0d dut%0d", cyc, k);
      check({p, " mem_en"},     mem_en[k],     e_en[k]);
      check({p, " busy"},       busy[k],       e_busy[k]);
      check({p, " i2c_ack"},    i2c_ack[k],    e_ack[k][I2C]);
      check({p, " host_ack"},   host_ack[k],   e_ack[k][HOST]);
      check({p, " grant_i2c"},  grant_i2c[k],  e_gnt[k]);
      check({p, " i2c_rdata"},  i2c_rdata[k],  e_rd[k][I2C]);
      check({p, " host_rdata"}, host_rdata[k], e_rd[k][HOST]);
      if (e_en[k]) begin
        check({p, " mem_we"},   mem_we[k],   gwe[k]);
        check({p, " mem_addr"}, mem_addr[k], gaddr[k]);
        if (gwe[k]) check({p, " mem_wdata"}, mem_wdata[k], gwd[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, at;
    model_reset();
    drive();
    repeat (2) @(negedge clk);
    check("reset mem_en",     mem_en,     0);
    check("reset mem_we",     mem_we,     0);
    check("reset mem_addr",   mem_addr,   0);
    check("reset mem_wdata",  mem_wdata,  0);
    check("reset acks",       {i2c_ack, host_ack}, 0);
    check("reset busy",       busy,       0);
    check("reset grant_i2c",  grant_i2c,  0);
    check("reset i2c_rdata",  i2c_rdata,  0);
    check("reset host_rdata", host_rdata, 0);
    rst_n = 1'b1;

    // Round-robin from reset: I2C first, then alternating every 3 cycles.
    hold[1][I2C] = 1'b1; hold[1][HOST] = 1'b1;
    rand_op(1, I2C); rand_op(1, HOST);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 2)  check("rr ack1 i2c",  i2c_ack[1],  1);
      if (i == 5)  check("rr ack2 host", host_ack[1], 1);
      if (i == 8)  check("rr ack3 i2c",  i2c_ack[1],  1);
      if (i == 11) check("rr ack4 host", host_ack[1], 1);
      n += int'(i2c_ack[1]) + int'(host_ack[1]);
    end
    check("rr ack count", n, 4);
    hold[1][I2C] = 1'b0; hold[1][HOST] = 1'b0;
    repeat (6) step();

    // Single I2C write then read of 0x10.
    set_op(0, I2C, 1'b1, 8'h10, 8'hA5);
    step(); step();
    check("wr mem_en",    mem_en[0],    1);
    check("wr mem_we",    mem_we[0],    1);
    check("wr mem_addr",  mem_addr[0],  8'h10);
    check("wr mem_wdata", mem_wdata[0], 8'hA5);
    step();
    check("wr i2c_ack",  i2c_ack[0],  1);
    check("wr host_ack", host_ack[0], 0);
    step();
    set_op(0, I2C, 1'b0, 8'h10, 8'h00);
    step(); step();
    check("rd mem_en",   mem_en[0],   1);
    check("rd mem_we",   mem_we[0],   0);
    check("rd mem_addr", mem_addr[0], 8'h10);
    step();
    check("rd i2c_ack",   i2c_ack[0],   1);
    check("rd i2c_rdata", i2c_rdata[0], 8'hA5);
    check("rd host_ack",  host_ack[0],  0);
    step();

    // Simultaneous requests under fixed priority.
    set_op(0, HOST, 1'b1, 8'h02, 8'h3C);
    repeat (4) step();
    set_op(0, I2C,  1'b0, 8'h01, 8'h00);
    set_op(0, HOST, 1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 2) begin
        check("tie i2c_ack@2",  i2c_ack[0],  1);
        check("tie host_ack@2", host_ack[0], 0);
      end
      if (i == 5) begin
        check("tie host_ack@5",   host_ack[0],   1);
        check("tie host_rdata@5", host_rdata[0], 8'h3C);
      end
    end
    step();

    // Starvation guard, run twice to show the wait counter starts over.
    for (int r = 0; r < 2; r++) begin
      hold[0][I2C] = 1'b1;
      rand_op(0, I2C);
      set_op(0, HOST, 1'b0, 8'h02, 8'h00);
      n = 0; at = -1;
      for (int i = 0; i < 16; i++) begin
        step();
        if (host_ack[0] && at < 0) at = i;
        if (i2c_ack[0] && at < 0) n++;
      end
      check($sformatf("starve run%0d i2c acks", r), n, 4);
      check($sformatf("starve run%0d host ack cycle", r), at, 14);
      hold[0][I2C] = 1'b0;
      repeat (6) step();
    end

    // Reset during ACCESS of a host write.
    set_op(0, HOST, 1'b1, 8'h20, 8'h99);
    step(); step();
    check("mid-rst pre mem_en", mem_en[0], 1);
    rst_n = 1'b0;
    #1;
    check("mid-rst mem_en",    mem_en,    0);
    check("mid-rst busy",      busy,      0);
    check("mid-rst acks",      {i2c_ack, host_ack}, 0);
    check("mid-rst grant_i2c", grant_i2c, 0);
    model_reset();
    drive();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post-rst host_ack", host_ack[0], 0);
      check("post-rst busy",     busy[0],     0);
    end

    // I2C drops its request during ACCESS.
    set_op(0, I2C, 1'b0, 8'h10, 8'h00);
    step();
    drp[0][I2C] = 1'b1;
    step();
    check("drop mem_en", mem_en[0], 1);
    step();
    check("drop i2c_ack",   i2c_ack[0],   1);
    check("drop i2c_rdata", i2c_rdata[0], 8'hA5);
    for (int i = 0; i < 4; i++) begin
      step();
      check("drop no reissue", mem_en[0], 0);
    end

    // Randomized traffic on both instances.
    rate = 30;
    drop_en = 1'b1;
    repeat (1500) step();
    rate = 0;
    drop_en = 1'b0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
